// File: rtl/assay_sequencer.sv
// rtl/assay_sequencer.sv - mix/heat/filter/detect assay sequencer
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       one-cycle request to run an assay (accepted only when idle)
//   dwell_mix/heat/filt         stage lengths in cycles (0 behaves as 1)
//   det_tmo                     max cycles to wait for det_ack (0 behaves as 1)
//   valve_src, valve_mix        open during MIX
//   heater_en                   on during HEAT
//   valve_filt                  open during FILT
//   det_req                     asserted during DET
//   det_ack, det_data           detector handshake and sample
//   busy                        assay in progress
//   done                        one-cycle completion pulse
//   result                      last captured sample (0 after a timeout)
//   timeout                     last assay timed out; cleared on the next accepted start
module assay_sequencer #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  dwell_mix,
  input  logic [CNT_W-1:0]  dwell_heat,
  input  logic [CNT_W-1:0]  dwell_filt,
  input  logic [CNT_W-1:0]  det_tmo,
  output logic              valve_src,
  output logic              valve_mix,
  output logic              heater_en,
  output logic              valve_filt,
  output logic              det_req,
  input  logic              det_ack,
  input  logic [DATA_W-1:0] det_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_MIX, S_HEAT, S_FILT, S_DET, S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [CNT_W-1:0]   r_dwell_heat;
  logic [CNT_W-1:0]   r_dwell_filt;
  logic [CNT_W-1:0]   r_det_tmo;
  logic               w_accept;
  logic               w_capture;
  logic               w_expire;
  logic               r_valve_src;
  logic               r_valve_mix;
  logic               r_heater_en;
  logic               r_valve_filt;
  logic               r_det_req;
  logic               r_busy;
  logic               r_done;
  logic [DATA_W-1:0]  r_result;
  logic               r_timeout;

  // Counter preload: a stage of length max(d,1) counts down from max(d,1)-1 to 0.
  function automatic logic [CNT_W-1:0] f_len_m1(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_expire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_MIX;
          w_cnt_next   = f_len_m1(dwell_mix);
        end
      end
      S_MIX: begin
        if (r_cnt == '0) begin
          w_next_state = S_HEAT;
          w_cnt_next   = f_len_m1(r_dwell_heat);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_HEAT: begin
        if (r_cnt == '0) begin
          w_next_state = S_FILT;
          w_cnt_next   = f_len_m1(r_dwell_filt);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_FILT: begin
        if (r_cnt == '0) begin
          w_next_state = S_DET;
          w_cnt_next   = f_len_m1(r_det_tmo);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_DET: begin
        // An ack in the expiry cycle is checked first, so it wins over the timeout.
        if (det_ack) begin
          w_capture    = 1'b1;
          w_next_state = S_DONE;
        end else if (r_cnt == '0) begin
          w_expire     = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_dwell_heat <= '0;
      r_dwell_filt <= '0;
      r_det_tmo    <= '0;
      r_valve_src  <= 1'b0;
      r_valve_mix  <= 1'b0;
      r_heater_en  <= 1'b0;
      r_valve_filt <= 1'b0;
      r_det_req    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_cnt_next;
      r_valve_src  <= (w_next_state == S_MIX);
      r_valve_mix  <= (w_next_state == S_MIX);
      r_heater_en  <= (w_next_state == S_HEAT);
      r_valve_filt <= (w_next_state == S_FILT);
      r_det_req    <= (w_next_state == S_DET);
      r_busy       <= (w_next_state != S_IDLE);
      r_done       <= (w_next_state == S_DONE);
      if (w_accept) begin
        r_dwell_heat <= dwell_heat;
        r_dwell_filt <= dwell_filt;
        r_det_tmo    <= det_tmo;
        r_timeout    <= 1'b0;
      end
      if (w_capture) begin
        r_result  <= det_data;
        r_timeout <= 1'b0;
      end
      if (w_expire) begin
        r_result  <= '0;
        r_timeout <= 1'b1;
      end
    end
  end

  assign valve_src  = r_valve_src;
  assign valve_mix  = r_valve_mix;
  assign heater_en  = r_heater_en;
  assign valve_filt = r_valve_filt;
  assign det_req    = r_det_req;
  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_assay_sequencer.sv
// tb/tb_assay_sequencer.sv - scoreboard bench for assay_sequencer
module tb_assay_sequencer;
  localparam int CNT_W  = 16;
  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  dwell_mix, dwell_heat, dwell_filt, det_tmo;
  logic              valve_src, valve_mix, heater_en, valve_filt, det_req;
  logic              det_ack;
  logic [DATA_W-1:0] det_data;
  logic              busy, done, timeout;
  logic [DATA_W-1:0] result;

  assay_sequencer #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dwell_mix(dwell_mix), .dwell_heat(dwell_heat), .dwell_filt(dwell_filt), .det_tmo(det_tmo),
    .valve_src(valve_src), .valve_mix(valve_mix), .heater_en(heater_en), .valve_filt(valve_filt),
    .det_req(det_req), .det_ack(det_ack), .det_data(det_data),
    .busy(busy), .done(done), .result(result), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                src_len, mix_len, heat_len, filt_len, det_len, lat, start_cyc;
    logic [DATA_W-1:0] res;
    logic              tmo;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0, n_acc = 0, n_done = 0, cyc = 0;
  int plan_k = 1;
  logic [DATA_W-1:0] plan_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // which: 0 = idle, 1 = heater on, 2 = done pulse; leaves caller at the negedge of the hit
  task automatic wait_cond(input int which, input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((which == 0 && !busy) || (which == 1 && heater_en) || (which == 2 && done)) return;
    end
    chk(name, 0, 1);
  endtask

  // Detector model: acks on the plan_k-th DET cycle; random noise on ack/data outside DET.
  initial begin
    int rcnt;
    rcnt = 0;
    det_ack = 1'b0;
    det_data = '0;
    forever begin
      @(negedge clk);
      if (det_req) begin
        rcnt++;
        det_ack  = (rcnt == plan_k);
        det_data = det_ack ? plan_data : DATA_W'($urandom);
      end else begin
        rcnt     = 0;
        det_ack  = 1'($urandom_range(0, 1));
        det_data = DATA_W'($urandom);
      end
    end
  end

  // Monitor: counts actuator cycles per assay and checks each done against the scoreboard.
  initial begin
    int c_src, c_mix, c_heat, c_filt, c_det;
    bit prev_done, prev_busy;
    exp_t e;
    c_src = 0; c_mix = 0; c_heat = 0; c_filt = 0; c_det = 0;
    prev_done = 0; prev_busy = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        c_src = 0; c_mix = 0; c_heat = 0; c_filt = 0; c_det = 0;
        prev_done = 0; prev_busy = 0;
        continue;
      end
      if (prev_done) begin
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
      end
      if (busy && !prev_busy) chk("timeout_cleared_on_start", timeout, 0);
      c_src += valve_src; c_mix += valve_mix; c_heat += heater_en;
      c_filt += valve_filt; c_det += det_req;
      if (done) begin
        n_done++;
        chk("done_actuators_off", {valve_src, valve_mix, heater_en, valve_filt, det_req}, 0);
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("src_len", c_src, e.src_len);
          chk("mix_len", c_mix, e.mix_len);
          chk("heat_len", c_heat, e.heat_len);
          chk("filt_len", c_filt, e.filt_len);
          chk("det_len", c_det, e.det_len);
          chk("latency", cyc - e.start_cyc, e.lat);
          chk("result", result, e.res);
          chk("timeout", timeout, e.tmo);
        end
        c_src = 0; c_mix = 0; c_heat = 0; c_filt = 0; c_det = 0;
      end
      prev_done = done;
      prev_busy = busy;
    end
  end

  task automatic launch(input int dm, dh, df, tmo, k, input logic [DATA_W-1:0] data, input bit push);
    exp_t e;
    bit ok;
    wait_cond(0, "idle_wait");
    dwell_mix = CNT_W'(dm); dwell_heat = CNT_W'(dh); dwell_filt = CNT_W'(df); det_tmo = CNT_W'(tmo);
    plan_k = k; plan_data = data;
    ok = (k <= eff(tmo));
    e.src_len = eff(dm); e.mix_len = eff(dm); e.heat_len = eff(dh); e.filt_len = eff(df);
    e.det_len = ok ? k : eff(tmo);
    e.lat = 1 + e.mix_len + e.heat_len + e.filt_len + e.det_len;
    e.res = ok ? data : '0;
    e.tmo = !ok;
    e.start_cyc = cyc;
    if (push) begin
      q.push_back(e);
      n_acc++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Latched values must be used from here on.
    dwell_mix = CNT_W'($urandom_range(0, 15)); dwell_heat = CNT_W'($urandom_range(0, 15));
    dwell_filt = CNT_W'($urandom_range(0, 15)); det_tmo = CNT_W'($urandom_range(0, 15));
  endtask

  task automatic run(input int dm, dh, df, tmo, k, input logic [DATA_W-1:0] data, input bit extra);
    launch(dm, dh, df, tmo, k, data, 1'b1);
    if (extra) begin
      wait_cond(1, "heat_wait");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cond(2, "done_wait");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    dwell_mix = '0; dwell_heat = '0; dwell_filt = '0; det_tmo = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {valve_src, valve_mix, heater_en, valve_filt, det_req, busy, done, timeout}, 0);
    chk("reset_result", result, 0);
    @(posedge clk); #1 rst = 1'b0;

    run(3, 2, 4, 10, 2, 12'hABC, 1'b0);    // nominal
    run(2, 1, 1, 5, 99, 12'h123, 1'b0);    // timeout
    run(0, 0, 0, 1, 1, 12'h5A5, 1'b0);     // zero dwell, ack on expiry cycle
    run(1, 3, 2, 4, 4, 12'h0F0, 1'b0);     // ack on expiry cycle, longer wait
    run(2, 3, 1, 6, 3, 12'h777, 1'b1);     // extra starts in HEAT and DONE

    // Reset in the middle of HEAT: nothing from that run may surface.
    launch(2, 5, 2, 3, 1, 12'hFFF, 1'b0);
    wait_cond(1, "heat_wait_rst");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {valve_src, valve_mix, heater_en, valve_filt, det_req, busy, done, timeout}, 0);
    chk("midrst_result", result, 0);
    run(1, 2, 1, 3, 2, 12'h321, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
          $urandom_range(0, 6), $urandom_range(1, 8), DATA_W'($urandom),
          ($urandom_range(0, 3) == 0));
    end

    wait_cond(0, "final_idle");
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    chk("done_count", n_done, n_acc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
